// File: rtl/fetch_redirect_pkg.sv
// Shared fetch/pipeline definitions: opcode enum, fetch FSM states, BTB entry
// layout and PC constants used by fetch_redirect and its BTB.
package fetch_redirect_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Tag is held zero-extended to 32 bits so the layout is independent of depth.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/fetch_redirect_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// single update port driven by execute-stage resolution.
module fetch_redirect_btb
  import fetch_redirect_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic [31:0] lk_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int IDX = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [31:0]        tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic [IDX-1:0] lk_idx;
  logic [IDX-1:0] up_idx;
  btb_entry_t     lk_ent;
  logic           up_match;

  assign lk_idx = lk_pc[IDX+1:2];
  assign up_idx = upd_pc[IDX+1:2];

  // Reads see pre-update contents when lookup and update share an index.
  assign lk_ent    = '{valid: valid_q[lk_idx], tag: tag_q[lk_idx], target: tgt_q[lk_idx]};
  assign lk_hit    = lk_ent.valid && (lk_ent.tag == pc_tag(lk_pc, IDX));
  assign lk_target = lk_ent.target;
  assign up_match  = (tag_q[up_idx] == pc_tag(upd_pc, IDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (upd_en) begin
      if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
      end else if (up_match) begin
        valid_q[up_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      tag_q[up_idx] <= pc_tag(upd_pc, IDX);
      tgt_q[up_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_redirect.sv
// Program counter owner: steers fetch on execute-stage redirects and squashes
// wrong-path IF/ID and ID/EX. BTB prediction is enabled by BTB_PREDICT_EN.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        ex_valid_i,
  input  logic        ex_is_cf_i,
  input  logic        br_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic [31:0] if_pc_o,
  output logic        if_valid_o,
  output logic        if_pred_taken_o,
  output logic [31:0] if_pred_target_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic [31:0] mispredict_cnt_o
);

  if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_depth
    $error("BTB_ENTRIES must be a power of two and at least 2");
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  cnt_q;
  logic         valid_q;

  logic         resolve;
  logic         redirect;
  logic [31:0]  fix_target;
  logic [31:0]  next_pc;
  logic         pred_hit;
  logic [31:0]  pred_tgt;

  assign resolve    = ex_valid_i & ex_is_cf_i;
  // Nothing in EX is real while booting, so a redirect is only honoured in RUN.
  assign redirect   = (state_q == RUN) & resolve &
                      ((br_taken_i != ex_pred_taken_i) |
                       (br_taken_i & (ex_target_i != ex_pred_target_i)));
  assign fix_target = br_taken_i ? ex_target_i : ex_pc_i + PC_INC;

`ifdef BTB_PREDICT_EN
  logic        lk_hit;
  logic [31:0] lk_target;

  fetch_redirect_btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_pc      (pc_q),
    .lk_hit     (lk_hit),
    .lk_target  (lk_target),
    .upd_en     (resolve),
    .upd_pc     (ex_pc_i),
    .upd_taken  (br_taken_i),
    .upd_target (ex_target_i)
  );

  assign pred_hit = lk_hit;
  assign pred_tgt = lk_hit ? lk_target : 32'd0;
`else
  assign pred_hit = 1'b0;
  assign pred_tgt = 32'd0;
`endif

  always_comb begin
    next_pc = pc_q + PC_INC;
    if (redirect) begin
      next_pc = fix_target;
    end else if (stall_i) begin
      next_pc = pc_q;
    end else if (pred_hit) begin
      next_pc = pred_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
          pc_q    <= RESET_PC;
        end
        default: begin
          pc_q <= next_pc;
        end
      endcase
      if (redirect) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  assign if_pc_o          = pc_q;
  assign if_valid_o       = valid_q;
  assign if_pred_taken_o  = pred_hit;
  assign if_pred_target_o = pred_tgt;
  assign flush_if_id_o    = redirect;
  assign flush_id_ex_o    = redirect;
  assign mispredict_cnt_o = cnt_q;

endmodule
